// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared command/response codes, FSM states and timeout default
package uart_pkg;
   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   // About five character times at 115200 baud on a 50 MHz clock
   localparam int TIMEOUT_CYCLES_DEFAULT = 21700;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      EXEC,
      SEND,
      SEND_WAIT
   } state_e;
endpackage

// File: rtl/uart_cmd_responder_if.sv
// rtl/uart_cmd_responder_if.sv - byte handshakes between UART rx/tx and the responder
interface uart_cmd_responder_if;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       rx_rdy_clr;
   logic       tx_busy;
   logic [7:0] tx_din;
   logic       tx_wr_en;

   modport master (input rx_rdy, rx_data, tx_busy, output rx_rdy_clr, tx_din, tx_wr_en);
   modport slave  (output rx_rdy, rx_data, tx_busy, input rx_rdy_clr, tx_din, tx_wr_en);
endinterface

// File: rtl/uart_cmd_regfile.sv
// rtl/uart_cmd_regfile.sv - NUM_REGS x 8 register file, one write port, combinational read
module uart_cmd_regfile #(
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [7:0]            wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [7:0]            rdata_o,
   output logic [8*NUM_REGS-1:0] regs_o
);
   logic [7:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = regs_q[raddr_i];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[8*g +: 8] = regs_q[g];
   end
endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - decodes 'W'/'R' register commands from UART bytes and
// returns one response byte per command
module uart_cmd_responder
   import uart_pkg::*;
#(
   parameter int NUM_REGS       = 4,
   parameter int ADDR_W         = $clog2(NUM_REGS),
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                     clk_50m,
   input  logic                     rst,
   uart_cmd_responder_if.master     bus,
   output logic [8*NUM_REGS-1:0]    regs_out,
   output logic                     cmd_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        tx_din_q, tx_din_d;
   logic              wr_en_q, wr_en_d;
   logic              cmd_err_q, cmd_err_d;
   logic              first_q, first_d;
   logic              clr_q;
   logic [TW-1:0]     tcnt_q, tcnt_d;

   logic              accept, in_cmd, timed_out, addr_bad, reg_we;
   logic [7:0]        rdata;

   uart_cmd_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_regfile (
      .clk     (clk_50m),
      .rst     (rst),
      .we_i    (reg_we),
      .waddr_i (addr_q),
      .wdata_i (data_q),
      .raddr_i (addr_q),
      .rdata_o (rdata),
      .regs_o  (regs_out)
   );

   // rx_rdy is still high in the cycle rx_rdy_clr is out, so skip that cycle
   assign accept    = (state_q inside {IDLE, GET_ADDR, GET_DATA}) && bus.rx_rdy && !clr_q;
   assign in_cmd    = state_q inside {GET_ADDR, GET_DATA};
   assign timed_out = in_cmd && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign addr_bad  = (bus.rx_data >> ADDR_W) != 8'd0;

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      err_d     = err_q;
      addr_d    = addr_q;
      data_d    = data_q;
      tx_din_d  = tx_din_q;
      wr_en_d   = 1'b0;
      cmd_err_d = 1'b0;
      first_d   = 1'b0;
      reg_we    = 1'b0;
      tcnt_d    = (accept || !in_cmd) ? '0 : tcnt_q + TW'(1);

      case (state_q)
         IDLE: if (accept) begin
            is_wr_d = (bus.rx_data == CMD_WR);
            if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
               err_d   = 1'b0;
               state_d = GET_ADDR;
            end else begin
               err_d   = 1'b1;
               state_d = EXEC;
            end
         end
         GET_ADDR: if (accept) begin
            addr_d  = bus.rx_data[ADDR_W-1:0];
            err_d   = addr_bad;
            state_d = is_wr_q ? GET_DATA : EXEC;
         end else if (timed_out) begin
            state_d = IDLE;
         end
         GET_DATA: if (accept) begin
            data_d  = bus.rx_data;
            state_d = EXEC;
         end else if (timed_out) begin
            state_d = IDLE;
         end
         EXEC: begin
            if (err_q) begin
               tx_din_d  = RSP_ERR;
               cmd_err_d = 1'b1;
            end else if (is_wr_q) begin
               reg_we   = 1'b1;
               tx_din_d = RSP_OK;
            end else begin
               tx_din_d = rdata;
            end
            state_d = SEND;
         end
         SEND: if (!bus.tx_busy) begin
            wr_en_d = 1'b1;
            first_d = 1'b1;
            state_d = SEND_WAIT;
         end
         // The transmitter raises tx_busy one cycle after wr_en, so the first cycle is blind
         SEND_WAIT: if (!first_q && !bus.tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         is_wr_q   <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= 8'h00;
         tx_din_q  <= 8'h00;
         wr_en_q   <= 1'b0;
         cmd_err_q <= 1'b0;
         first_q   <= 1'b0;
         clr_q     <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         tx_din_q  <= tx_din_d;
         wr_en_q   <= wr_en_d;
         cmd_err_q <= cmd_err_d;
         first_q   <= first_d;
         clr_q     <= accept;
         tcnt_q    <= tcnt_d;
      end
   end

   assign bus.rx_rdy_clr = clr_q;
   assign bus.tx_din     = tx_din_q;
   assign bus.tx_wr_en   = wr_en_q;
   assign cmd_err        = cmd_err_q;
endmodule
